// File: rtl/snd_host_pkg.sv
// Shared types and defaults for the 68k-side sound mailbox host (snd_cmd_host).
package snd_host_pkg;

   localparam int unsigned STROBE_TICKS_DEF  = 2;
   localparam int unsigned RSP_DEPTH_DEF     = 4;
   localparam int unsigned TIMEOUT_TICKS_DEF = 4096;

   // Wide enough for STROBE_TICKS up to 15.
   localparam int unsigned StbCntW = 4;

   typedef enum logic [3:0] {
      StIdle,
      StWrSetup,
      StWrStb,
      StWrRel,
      StWrWait,
      StRdSetup,
      StRdStb,
      StRdRel,
      StRdWait
   } host_state_e;

endpackage

// File: rtl/snd_rsp_fifo.sv
// Byte-wide synchronous response FIFO; head is visible combinationally on data_o.
module snd_rsp_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       push_i,
   input  logic [7:0] data_i,
   input  logic       pop_i,
   output logic [7:0] data_o,
   output logic       full_o,
   output logic       empty_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [7:0]      mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q;
   logic            push_ok, pop_ok;

   assign full_o  = (count_q == CntW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;
   assign data_o  = mem_q[rd_ptr_q];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + CntW'(push_ok) - CntW'(pop_ok);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/snd_cmd_host.sv
// 68k-side mailbox endpoint: writes commands into the sound latch, drains 6502 responses.
// Define SND_TIMEOUT_EN to bound the WR_WAIT/RD_WAIT handshakes and enable the timeout flag.
module snd_cmd_host
   import snd_host_pkg::*;
#(
   parameter int unsigned STROBE_TICKS  = STROBE_TICKS_DEF,
   parameter int unsigned RSP_DEPTH     = RSP_DEPTH_DEF,
   parameter int unsigned TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
   input  logic       clk100_i,
   input  logic       rst_b_i,
   input  logic       tick_en_i,
   input  logic       cmd_valid_i,
   output logic       cmd_ready_o,
   input  logic [7:0] cmd_data_i,
   output logic       rsp_valid_o,
   input  logic       rsp_ready_i,
   output logic [7:0] rsp_data_o,
   output logic [7:0] Dout68k_o,
   input  logic [7:0] Din68k_i,
   output logic       SNDWR_b_o,
   output logic       SNDRD_b_o,
   output logic       IBUS_b_o,
   output logic       BW_b_o,
   input  logic       ctrl_SNDBUF_i,
   input  logic       SNDINT_b_i,
   output logic       busy_o,
   output logic       timeout_o
);

   if (STROBE_TICKS < 1 || STROBE_TICKS > 15) begin : g_bad_stb
      $error("STROBE_TICKS must be in 1..15");
   end
   if (RSP_DEPTH < 2 || (RSP_DEPTH & (RSP_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("RSP_DEPTH must be a power of 2, at least 2");
   end
   if (TIMEOUT_TICKS < 1 || TIMEOUT_TICKS > 65535) begin : g_bad_timeout
      $error("TIMEOUT_TICKS must fit the 16-bit tick counter");
   end

   host_state_e        state_q, state_d;
   logic [StbCntW-1:0] stb_cnt_q, stb_cnt_d;
   logic [7:0]         hold_q, dout_q;
   logic               hold_full_q;
   logic               sndwr_q, sndrd_q, ibus_q, bw_q;
   logic               rsp_push, hold_clr, wr_load, wait_expired;
   logic               fifo_full, fifo_empty;
   logic               stb_last;

   assign stb_last = (stb_cnt_q == StbCntW'(STROBE_TICKS - 1));

`ifdef SND_TIMEOUT_EN
   logic [15:0] to_cnt_q;
   logic        timeout_q, in_wait, wait_done;

   assign in_wait   = (state_q == StWrWait) | (state_q == StRdWait);
   assign wait_done = ((state_q == StWrWait) & ctrl_SNDBUF_i) |
                      ((state_q == StRdWait) & SNDINT_b_i);
   assign wait_expired = tick_en_i & in_wait & ~wait_done &
                         ((to_cnt_q + 16'd1) == 16'(TIMEOUT_TICKS));

   // Cleared whenever outside a wait state, so each wait starts counting from zero.
   always_ff @(posedge clk100_i or negedge rst_b_i) begin
      if (!rst_b_i) begin
         to_cnt_q  <= '0;
         timeout_q <= 1'b0;
      end else if (tick_en_i) begin
         to_cnt_q <= in_wait ? to_cnt_q + 16'd1 : 16'd0;
         if (wait_expired) timeout_q <= 1'b1;
      end
   end

   assign timeout_o = timeout_q;
`else
   assign wait_expired = 1'b0;
   assign timeout_o    = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      stb_cnt_d = stb_cnt_q;
      rsp_push  = 1'b0;
      hold_clr  = 1'b0;
      wr_load   = 1'b0;
      if (tick_en_i) begin
         case (state_q)
            StIdle: begin
               // Reads win; a full FIFO stalls the 6502 rather than dropping a byte.
               if (!SNDINT_b_i && !fifo_full) begin
                  state_d = StRdSetup;
               end else if (hold_full_q && !ctrl_SNDBUF_i) begin
                  state_d = StWrSetup;
                  wr_load = 1'b1;
               end
            end
            StWrSetup: begin
               state_d   = StWrStb;
               stb_cnt_d = '0;
            end
            StWrStb: begin
               if (stb_last) state_d = StWrRel;
               else stb_cnt_d = stb_cnt_q + 1'b1;
            end
            StWrRel: begin
               state_d  = StWrWait;
               hold_clr = 1'b1;
            end
            StWrWait: if (ctrl_SNDBUF_i || wait_expired) state_d = StIdle;
            StRdSetup: begin
               state_d   = StRdStb;
               stb_cnt_d = '0;
            end
            StRdStb: begin
               if (stb_last) begin
                  state_d  = StRdRel;
                  rsp_push = 1'b1;
               end else begin
                  stb_cnt_d = stb_cnt_q + 1'b1;
               end
            end
            StRdRel: state_d = StRdWait;
            StRdWait: if (SNDINT_b_i || wait_expired) state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   // Strobes are registered from the next state, so they only move on tick edges.
   always_ff @(posedge clk100_i or negedge rst_b_i) begin
      if (!rst_b_i) begin
         state_q     <= StIdle;
         stb_cnt_q   <= '0;
         hold_q      <= 8'h00;
         hold_full_q <= 1'b0;
         dout_q      <= 8'h00;
         sndwr_q     <= 1'b1;
         sndrd_q     <= 1'b1;
         ibus_q      <= 1'b1;
         bw_q        <= 1'b1;
      end else begin
         state_q   <= state_d;
         stb_cnt_q <= stb_cnt_d;
         if (cmd_valid_i && !hold_full_q) begin
            hold_q      <= cmd_data_i;
            hold_full_q <= 1'b1;
         end else if (hold_clr) begin
            hold_full_q <= 1'b0;
         end
         if (wr_load) dout_q <= hold_q;
         sndwr_q <= ~(state_d == StWrStb);
         sndrd_q <= ~(state_d == StRdStb);
         ibus_q  <= ~(state_d inside {StWrSetup, StWrStb, StRdSetup, StRdStb});
         bw_q    <= ~(state_d inside {StWrSetup, StWrStb});
      end
   end

   snd_rsp_fifo #(
      .DEPTH(RSP_DEPTH)
   ) u_rsp_fifo (
      .clk_i  (clk100_i),
      .rst_ni (rst_b_i),
      .push_i (rsp_push),
      .data_i (Din68k_i),
      .pop_i  (rsp_ready_i),
      .data_o (rsp_data_o),
      .full_o (fifo_full),
      .empty_o(fifo_empty)
   );

   assign cmd_ready_o = ~hold_full_q;
   assign rsp_valid_o = ~fifo_empty;
   assign busy_o      = (state_q != StIdle) | hold_full_q;
   assign Dout68k_o   = dout_q;
   assign SNDWR_b_o   = sndwr_q;
   assign SNDRD_b_o   = sndrd_q;
   assign IBUS_b_o    = ibus_q;
   assign BW_b_o      = bw_q;

endmodule

// File: tb/tb_snd_cmd_host.sv
// Scoreboard bench for snd_cmd_host: io_interface/6502 model, byte-order queues, strobe widths.
module tb_snd_cmd_host;

   localparam int STROBE = 2;

   logic       clk = 1'b0;
   logic       rst_b = 1'b0;
   logic       tick_en = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [7:0] cmd_data = 8'h00;
   logic       rsp_ready = 1'b0;
   logic [7:0] Din68k = 8'h00;
   logic       ctrl_SNDBUF = 1'b0;
   logic       SNDINT_b = 1'b1;
   logic       cmd_ready, rsp_valid, busy, timeout;
   logic [7:0] rsp_data, Dout68k;
   logic       SNDWR_b, SNDRD_b, IBUS_b, BW_b;

   snd_cmd_host #(
      .STROBE_TICKS (STROBE),
      .RSP_DEPTH    (4),
      .TIMEOUT_TICKS(8)
   ) dut (
      .clk100_i     (clk),
      .rst_b_i      (rst_b),
      .tick_en_i    (tick_en),
      .cmd_valid_i  (cmd_valid),
      .cmd_ready_o  (cmd_ready),
      .cmd_data_i   (cmd_data),
      .rsp_valid_o  (rsp_valid),
      .rsp_ready_i  (rsp_ready),
      .rsp_data_o   (rsp_data),
      .Dout68k_o    (Dout68k),
      .Din68k_i     (Din68k),
      .SNDWR_b_o    (SNDWR_b),
      .SNDRD_b_o    (SNDRD_b),
      .IBUS_b_o     (IBUS_b),
      .BW_b_o       (BW_b),
      .ctrl_SNDBUF_i(ctrl_SNDBUF),
      .SNDINT_b_i   (SNDINT_b),
      .busy_o       (busy),
      .timeout_o    (timeout)
   );

   initial forever #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Expected byte streams and environment state
   logic [7:0] exp_cmd[$];
   logic [7:0] exp_rsp[$];
   logic [7:0] rsp_src[$];
   logic [7:0] ev_log[$];
   int  div = 0;
   int  wr_t = 0, rd_t = 0, ib_t = 0, bw_t = 0;
   int  wr_count = 0, rd_count = 0;
   int  buf_dly = 0, latch_hold = 0, int_rel = 0, gap = 0;
   bit  latch_full = 0, force_buf = 0, hold_rsp = 0, no_ack = 0;
   logic prev_wr = 1'b1, prev_rd = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Tick generator, io_interface/6502 model and monitors, all sampled on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         div = (div + 1) % 4;
         tick_en = (div == 0);
         if (!rst_b) begin
            latch_full = 0; buf_dly = 0; int_rel = 0; gap = 0;
            wr_t = 0; rd_t = 0; ib_t = 0; bw_t = 0;
            prev_wr = 1'b1; prev_rd = 1'b1;
            SNDINT_b = 1'b1; rsp_ready = 1'b0;
            ctrl_SNDBUF = force_buf;
         end else begin
            if (tick_en) begin
               if (!SNDWR_b) wr_t++;
               if (!SNDRD_b) rd_t++;
               if (!IBUS_b)  ib_t++;
               if (!BW_b)    bw_t++;
            end
            if (!prev_wr && SNDWR_b) begin
               chk("wr_strobe_ticks", wr_t, STROBE);
               chk("wr_ibus_ticks", ib_t, STROBE + 1);
               chk("wr_bw_ticks", bw_t, STROBE + 1);
               if (exp_cmd.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL cmd_unexpected: got %0h expected none", Dout68k);
               end else begin
                  chk("cmd_byte", Dout68k, exp_cmd.pop_front());
               end
               wr_count++; ev_log.push_back(8'h57);
               if (!no_ack) buf_dly = 1;
               wr_t = 0; ib_t = 0; bw_t = 0;
            end
            if (!prev_rd && SNDRD_b) begin
               chk("rd_strobe_ticks", rd_t, STROBE);
               chk("rd_ibus_ticks", ib_t, STROBE + 1);
               chk("rd_bw_low_ticks", bw_t, 0);
               rd_count++; ev_log.push_back(8'h52);
               int_rel = 1;
               rd_t = 0; ib_t = 0; bw_t = 0;
            end
            prev_wr = SNDWR_b;
            prev_rd = SNDRD_b;
            if (tick_en) begin
               if (buf_dly > 0) begin
                  buf_dly--;
                  if (buf_dly == 0) begin
                     latch_full = 1;
                     latch_hold = $urandom_range(2, 6);
                  end
               end else if (latch_full) begin
                  if (latch_hold == 0) latch_full = 0;
                  else latch_hold--;
               end
               if (int_rel > 0) begin
                  int_rel--;
                  if (int_rel == 0) begin
                     SNDINT_b = 1'b1;
                     gap = 2;
                  end
               end else if (gap > 0) begin
                  gap--;
               end
            end
            ctrl_SNDBUF = force_buf | latch_full;
            if (SNDINT_b && int_rel == 0 && gap == 0 && rsp_src.size() > 0) begin
               Din68k = rsp_src.pop_front();
               exp_rsp.push_back(Din68k);
               SNDINT_b = 1'b0;
            end
            rsp_ready = hold_rsp ? 1'b0 : 1'($urandom_range(0, 1));
            if (rsp_valid && rsp_ready) begin
               if (exp_rsp.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL rsp_unexpected: got %0h expected none", rsp_data);
               end else begin
                  chk("rsp_byte", rsp_data, exp_rsp.pop_front());
               end
            end
         end
      end
   end

   task automatic send_cmd(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_data  = b;
      while (!cmd_ready && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("cmd_accept_in_time", cmd_ready, 1'b1);
      if (cmd_ready) exp_cmd.push_back(b);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (n < 20000 && !(busy == 1'b0 && rsp_src.size() == 0 && exp_rsp.size() == 0 &&
                            exp_cmd.size() == 0 && SNDINT_b && int_rel == 0 && gap == 0 &&
                            !latch_full && buf_dly == 0)) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_idle_reached"}, 32'(n < 20000), 1);
   endtask

   task automatic wait_reads(input int target);
      int n = 0;
      while (rd_count < target && n < 20000) begin
         @(negedge clk);
         n++;
      end
      chk("read_count_reached", rd_count, target);
   endtask

   int base;

   initial begin
      repeat (3) @(negedge clk);
      #1;
      chk("rst_SNDWR_b", SNDWR_b, 1);
      chk("rst_SNDRD_b", SNDRD_b, 1);
      chk("rst_IBUS_b", IBUS_b, 1);
      chk("rst_BW_b", BW_b, 1);
      chk("rst_Dout68k", Dout68k, 8'h00);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_timeout", timeout, 0);
      @(negedge clk);
      rst_b = 1'b1;

      // Single command
      send_cmd(8'h42);
      chk("busy_while_cmd", busy, 1);
      wait_idle("single_cmd");
      chk("single_cmd_dout", Dout68k, 8'h42);
      chk("single_cmd_ready", cmd_ready, 1);
      chk("single_cmd_writes", wr_count, 1);

      // Blocked write while the latch reads full
      force_buf = 1;
      base = wr_count;
      send_cmd(8'h11);
      repeat (40) @(negedge clk);
      chk("blocked_no_write", wr_count, base);
      chk("blocked_cmd_ready", cmd_ready, 0);
      force_buf = 0;
      wait_idle("blocked");
      chk("blocked_one_write", wr_count, base + 1);

      // Single response, held in the FIFO
      hold_rsp = 1;
      base = rd_count;
      rsp_src.push_back(8'hA5);
      wait_reads(base + 1);
      repeat (12) @(negedge clk);
      chk("single_rsp_valid", rsp_valid, 1);
      chk("single_rsp_data", rsp_data, 8'hA5);
      hold_rsp = 0;
      wait_idle("single_rsp");

      // Read and write pending in the same tick: read goes first
      base = ev_log.size();
      do begin
         @(negedge clk);
         #1;
      end while (!tick_en);
      rsp_src.push_back(8'h3C);
      @(negedge clk);
      send_cmd(8'h5E);
      wait_idle("prio");
      chk("prio_first_read", ev_log[base], 8'h52);
      chk("prio_then_write", ev_log[base+1], 8'h57);

      // FIFO full stalls the fifth response without loss
      hold_rsp = 1;
      base = rd_count;
      for (int i = 1; i <= 5; i++) rsp_src.push_back(8'(i));
      wait_reads(base + 4);
      repeat (40) @(negedge clk);
      chk("full_reads_stalled", rd_count, base + 4);
      chk("full_sndint_pending", SNDINT_b, 0);
      chk("full_rsp_valid", rsp_valid, 1);
      chk("full_head", rsp_data, 8'h01);
      hold_rsp = 0;
      wait_idle("fifo_full");
      chk("full_all_reads", rd_count, base + 5);

      // Randomized mix of commands and responses
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 2))
            0: send_cmd(8'($urandom));
            1: rsp_src.push_back(8'($urandom));
            default: repeat ($urandom_range(1, 20)) @(negedge clk);
         endcase
      end
      wait_idle("random");

`ifdef SND_TIMEOUT_EN
      no_ack = 1;
      base = wr_count;
      send_cmd(8'h99);
      repeat (80) @(negedge clk);
      chk("to_write_done", wr_count, base + 1);
      chk("to_flag", timeout, 1);
      chk("to_back_idle", busy, 0);
      no_ack = 0;
`else
      chk("timeout_disabled", timeout, 0);
`endif

      // Reset during the write strobe
      begin
         int n = 0;
         send_cmd(8'h77);
         while (SNDWR_b && n < 2000) begin
            @(negedge clk);
            n++;
         end
         chk("mid_strobe_reached", SNDWR_b, 0);
         rst_b = 1'b0;
         #1;
         chk("mid_rst_SNDWR_b", SNDWR_b, 1);
         chk("mid_rst_IBUS_b", IBUS_b, 1);
         chk("mid_rst_cmd_ready", cmd_ready, 1);
         chk("mid_rst_rsp_valid", rsp_valid, 0);
         chk("mid_rst_timeout", timeout, 0);
         exp_cmd.delete();
         repeat (3) @(negedge clk);
         rst_b = 1'b1;
      end
      send_cmd(8'h5A);
      wait_idle("post_reset");
      chk("post_reset_dout", Dout68k, 8'h5A);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
